// File: rtl/execute_stage.sv
// execute_stage: EX pipeline stage with forwarding muxes, ALU, branch target adder and EX/MEM register.
// Optional macro EXECUTE_STAGE_MUL_EN adds a 32-cycle shift-add multiplier FSM (IDLE/BUSY/DONE)
// that stalls upstream while running; without it MUL (alu_op 1010) yields 0 and stall is tied 0.
// Ports: clk, rst_n (async active-low); idex_valid/idex_ctrl/alu_op/alu_src/rs1_data/rs2_data/imm/pc
// describe the ID/EX instruction; fwd_a/fwd_b select regfile, mem_fwd_data or wb_fwd_data; flush kills
// the EX instruction. Outputs EXMEM, ALUresult, Zero, WRITE_DATA, PCBranch_EXMEM, exmem_valid are
// registered; stall is combinational.
module execute_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        idex_valid,
   input  logic [44:0] idex_ctrl,
   input  logic [3:0]  alu_op,
   input  logic        alu_src,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [31:0] imm,
   input  logic [7:0]  pc,
   input  logic [1:0]  fwd_a,
   input  logic [1:0]  fwd_b,
   input  logic [31:0] mem_fwd_data,
   input  logic [31:0] wb_fwd_data,
   input  logic        flush,
   output logic [44:0] EXMEM,
   output logic [31:0] ALUresult,
   output logic        Zero,
   output logic [31:0] WRITE_DATA,
   output logic [7:0]  PCBranch_EXMEM,
   output logic        exmem_valid,
   output logic        stall
);
   localparam logic [3:0] OP_MUL = 4'b1010;
   logic [31:0] w_a, w_fb, w_b, w_alu, w_res, w_wd;
   logic [44:0] w_ctrl;
   logic [7:0]  w_br, w_pcb;
   logic        w_ld, w_ld_mul, w_take;
   assign w_a  = fwd_a == 2'b01 ? mem_fwd_data : fwd_a == 2'b10 ? wb_fwd_data : rs1_data;
   assign w_fb = fwd_b == 2'b01 ? mem_fwd_data : fwd_b == 2'b10 ? wb_fwd_data : rs2_data;
   assign w_b  = alu_src ? imm : w_fb;
   assign w_br = pc + imm[7:0];
   // MUL is never produced here: it either comes from the FSM or reads as 0.
   always_comb begin
      w_alu = '0;
      case (alu_op)
         4'b0000: w_alu = w_a + w_b;
         4'b0001: w_alu = w_a - w_b;
         4'b0010: w_alu = w_a & w_b;
         4'b0011: w_alu = w_a | w_b;
         4'b0100: w_alu = w_a ^ w_b;
         4'b0101: w_alu = w_a << w_b[4:0];
         4'b0110: w_alu = w_a >> w_b[4:0];
         4'b0111: w_alu = $signed(w_a) >>> w_b[4:0];
         4'b1000: w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
         4'b1001: w_alu = {31'd0, w_a < w_b};
         default: w_alu = '0;
      endcase
   end
`ifdef EXECUTE_STAGE_MUL_EN
   localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;
   logic [1:0]  r_state;
   logic [4:0]  r_cnt;
   logic [31:0] r_mcand, r_mplier, r_acc, r_wd;
   logic [44:0] r_ctrl;
   logic [7:0]  r_br;
   logic        w_launch, w_done;
   assign w_launch = r_state == S_IDLE && idex_valid && alu_op == OP_MUL && !flush;
   assign w_done   = r_state == S_DONE;
   // Gated by rst_n so upstream is released while reset is held.
   assign stall    = rst_n && (w_launch || r_state == S_BUSY);
   assign w_ld     = idex_valid && !flush && !stall && !w_done;
   assign w_ld_mul = w_done && !flush;
   assign w_ctrl   = w_ld_mul ? r_ctrl : idex_ctrl;
   assign w_res    = w_ld_mul ? r_acc : w_alu;
   assign w_wd     = w_ld_mul ? r_wd : w_fb;
   assign w_pcb    = w_ld_mul ? r_br : w_br;
   // One multiplier bit per BUSY cycle; the accumulator holds the low 32 product bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_wd     <= '0;
         r_ctrl   <= '0;
         r_br     <= '0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_launch) begin
               r_state  <= S_BUSY;
               r_cnt    <= '0;
               r_mcand  <= w_a;
               r_mplier <= w_b;
               r_acc    <= '0;
               r_wd     <= w_fb;
               r_ctrl   <= idex_ctrl;
               r_br     <= w_br;
            end
            S_BUSY: begin
               r_acc    <= r_acc + (r_mplier[0] ? r_mcand : 32'd0);
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 5'd1;
               r_state  <= r_cnt == 5'd31 ? S_DONE : S_BUSY;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
`else
   assign stall    = 1'b0;
   assign w_ld     = idex_valid && !flush;
   assign w_ld_mul = 1'b0;
   assign w_ctrl   = idex_ctrl;
   assign w_res    = w_alu;
   assign w_wd     = w_fb;
   assign w_pcb    = w_br;
`endif
   assign w_take = w_ld || w_ld_mul;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         EXMEM          <= '0;
         ALUresult      <= '0;
         Zero           <= 1'b0;
         WRITE_DATA     <= '0;
         PCBranch_EXMEM <= '0;
         exmem_valid    <= 1'b0;
      end else begin
         EXMEM          <= w_take ? w_ctrl : '0;
         ALUresult      <= w_take ? w_res : '0;
         Zero           <= w_take && w_res == 32'd0;
         WRITE_DATA     <= w_take ? w_wd : '0;
         PCBranch_EXMEM <= w_take ? w_pcb : '0;
         exmem_valid    <= w_take;
      end
   end
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  input  1  pipeline clock; all registers update on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 idex_valid  input  1  ID/EX holds a real instruction.
REQ-004 idex_ctrl  input  45  control bundle; [36] Branch, [35] MemRead, [34] MemWrite, [33:0] writeback-bound bits.
REQ-005 alu_op  input  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 MUL; others yield 0.
REQ-006 alu_src  input  1  operand B select: 1 = imm, 0 = forwarded rs2.
REQ-007 rs1_data, rs2_data, imm  input  32 each  register operands and sign-extended immediate.
REQ-008 pc  input  8  instruction address.
REQ-009 fwd_a, fwd_b  input  2 each  00 = regfile, 01 = mem_fwd_data, 10 = wb_fwd_data, 11 = regfile.
REQ-010 mem_fwd_data, wb_fwd_data  input  32 each  forwarding sources.
REQ-011 flush  input  1  kill the instruction currently in EX.
REQ-012 EXMEM  output  45  registered control bundle to memory stage.
REQ-013 ALUresult  output  32  registered ALU result.
REQ-014 Zero  output  1  registered; 1 when ALU result is zero.
REQ-015 WRITE_DATA  output  32  registered forwarded rs2 (store data).
REQ-016 PCBranch_EXMEM  output  8  registered branch target.
REQ-017 exmem_valid  output  1  registered valid.
REQ-018 stall  output  1  combinational; upstream holds PC, IF/ID and ID/EX while high.

Function
REQ-019 Operand A = fwd_a mux; forwarded B = fwd_b mux; operand B = alu_src ? imm : forwarded B.
REQ-020 Shifts use operand B[4:0]; SRA sign-fills; SLT signed, SLTU unsigned, result 0 or 1.
REQ-021 ADD/SUB/MUL are modulo 2^32; MUL returns low 32 bits of the unsigned product.
REQ-022 Branch target = pc + imm[7:0], modulo 256 (wraps 0xFF+0x01 -> 0x00).
REQ-023 Single-cycle ops: when not stalled, all EX/MEM outputs load on the next rising edge (latency 1).
REQ-024 Bubble: when idex_valid=0, flush=1 or stall=1, the edge loads EXMEM=0, exmem_valid=0, ALUresult=0, Zero=0, WRITE_DATA=0, PCBranch_EXMEM=0.
REQ-025 Multiplier FSM states IDLE, BUSY, DONE; IDLE->BUSY on valid MUL without flush; BUSY lasts exactly 32 cycles (5-bit counter, shift-add one bit per cycle); BUSY->DONE after the 32nd; DONE->IDLE unconditionally.
REQ-026 stall = (IDLE and valid MUL and not flush) or BUSY; stall=0 in DONE.
REQ-027 In DONE, the held MUL instruction's product and control load into EX/MEM; DONE does not re-launch the MUL.
REQ-028 Operands are captured on IDLE->BUSY; input changes during BUSY are ignored.
REQ-029 flush in BUSY or DONE aborts to IDLE, drops stall next cycle, loads a bubble.
REQ-030 flush takes priority over every other event in the same cycle.

Reset
REQ-031 rst_n low immediately clears all registered outputs to 0, FSM to IDLE, counter and product accumulator to 0.
REQ-032 Reset during BUSY discards the multiply; stall deasserts while rst_n is low.
REQ-033 First edge after rst_n rises behaves as from IDLE.

Configuration
REQ-034 Macro EXECUTE_STAGE_MUL_EN: defined -> multiplier FSM and MUL opcode present as above.
REQ-035 Undefined -> no FSM or multiplier logic; alu_op 1010 yields 0 in one cycle like any op; stall tied 0.

Verification
REQ-036 ADD rs1=0x7FFFFFFF, rs2=1, alu_src=0 -> next edge ALUresult=0x80000000, Zero=0, exmem_valid=1.
REQ-037 SUB rs1=5, fwd_b=01, mem_fwd_data=5, idex_ctrl[36]=1, pc=0xF0, imm=0x20 -> ALUresult=0, Zero=1, PCBranch_EXMEM=0x10, EXMEM[36]=1.
REQ-038 SRA rs1=0x80000000, imm=31, alu_src=1 -> ALUresult=0xFFFFFFFF; SLTU rs1=0xFFFFFFFF, rs2=1 -> 0.
REQ-039 MUL_EN: MUL 0x10000 x 0x10001 -> stall high 33 cycles, bubbles meanwhile, then ALUresult=0x00010000 with exmem_valid=1.
REQ-040 MUL_EN: flush in 10th BUSY cycle -> FSM IDLE, stall 0 next cycle, bubble; rst_n low mid-BUSY -> all outputs 0 at once.
REQ-041 Without macro: alu_op 1010 -> stall never asserts, ALUresult=0 after one edge.
